// File: rtl/sr_readback_if.sv
// Pin bundle between the serial readback engine and the rest of the chip:
// request handshake, result word and the shift-register chain pins.
interface sr_readback_if #(
  parameter int DATA_WIDTH = 170
);
  logic                  start;
  logic                  data_in;
  logic                  data_out;
  logic                  cap_sr;
  logic                  clk_sr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;
  logic                  busy;

  modport master (
    input  start, data_in,
    output data_out, cap_sr, clk_sr, dout, valid, busy
  );

  modport slave (
    output start, data_in,
    input  data_out, cap_sr, clk_sr, dout, valid, busy
  );
endinterface

// File: rtl/sr_readback.sv
// Serial readback of the configuration shift-register chain: capture, shift out
// with recirculation, and assemble the returning bits into one parallel word.
module sr_readback #(
  parameter int DATA_WIDTH      = 170,
  parameter int CNT_WIDTH       = 8,
  parameter bit SHIFT_DIRECTION = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  sr_readback_if.master bus
);

  typedef enum logic [2:0] {IDLE, CAPTURE, P0, P1, P2, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] shadow;

  // Bit k of the stream lands at the MSB end or the LSB end of the word.
  function automatic logic [CNT_WIDTH-1:0] place(input logic [CNT_WIDTH-1:0] k);
    return SHIFT_DIRECTION ? (LAST - k) : k;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CAPTURE;
      CAPTURE: state_nxt = P0;
      P0:      state_nxt = P1;
      P1:      state_nxt = P2;
      P2:      state_nxt = (cnt == LAST) ? DONE : P0;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.cap_sr   <= 1'b0;
      bus.clk_sr   <= 1'b0;
      bus.valid    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.data_out <= 1'b0;
      bus.dout     <= '0;
    end else begin
      state      <= state_nxt;
      bus.cap_sr <= (state_nxt == CAPTURE);
      bus.clk_sr <= (state_nxt == P2);
      bus.valid  <= (state_nxt == DONE);
      bus.busy   <= (state_nxt inside {CAPTURE, P0, P1, P2});

      if (state == CAPTURE)
        cnt <= '0;
      else if (state == P2)
        cnt <= cnt + 1'b1;

      // The sampled bit is fed straight back so the chain rotates to its start.
      if (state == P0)
        bus.data_out <= bus.data_in;
      else if (state_nxt inside {IDLE, CAPTURE, DONE})
        bus.data_out <= 1'b0;

      if (state_nxt == DONE)
        bus.dout <= shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (state == P0)
      shadow[place(cnt)] <= bus.data_in;
  end

endmodule

// File: tb/tb_sr_readback.sv
// Directed bench for sr_readback: three engines (MSB-first, LSB-first, 1-bit chain)
// each wired to a behavioural recirculating chain model.
module tb_sr_readback;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = 3'b000;

  always #5 clk = ~clk;

  sr_readback_if #(.DATA_WIDTH(170)) if_a ();
  sr_readback_if #(.DATA_WIDTH(170)) if_b ();
  sr_readback_if #(.DATA_WIDTH(1))   if_c ();

  sr_readback #(.DATA_WIDTH(170), .CNT_WIDTH(8), .SHIFT_DIRECTION(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  sr_readback #(.DATA_WIDTH(170), .CNT_WIDTH(8), .SHIFT_DIRECTION(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  sr_readback #(.DATA_WIDTH(1), .CNT_WIDTH(1), .SHIFT_DIRECTION(1'b1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  wire [2:0] valid_v = {if_c.valid, if_b.valid, if_a.valid};
  wire [2:0] busy_v  = {if_c.busy, if_b.busy, if_a.busy};
  wire [2:0] cap_v   = {if_c.cap_sr, if_b.cap_sr, if_a.cap_sr};

  assign if_a.start = start_v[0];
  assign if_b.start = start_v[1];
  assign if_c.start = start_v[2];

  // Chain models: capture cfg on cap_sr, rotate on each clk_sr rising edge.
  logic [169:0] cfg_a = '0, mdl_a = '0, cfg_b = '0, mdl_b = '0;
  logic         cfg_c = 1'b0, mdl_c = 1'b0;
  logic         prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;
  int edges_a = 0, edges_b = 0, edges_c = 0;
  int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
  int derr_a = 0, derr_b = 0, derr_c = 0;

  assign if_a.data_in = mdl_a[169];
  assign if_b.data_in = mdl_b[0];
  assign if_c.data_in = mdl_c;

  always @(posedge clk) begin
    prev_a <= if_a.clk_sr;
    if (if_a.valid) vcnt_a <= vcnt_a + 1;
    if (!if_a.busy && if_a.data_out) derr_a <= derr_a + 1;
    if (if_a.cap_sr) mdl_a <= cfg_a;
    else if (if_a.clk_sr && !prev_a) begin
      if (if_a.data_out !== mdl_a[169]) derr_a <= derr_a + 1;
      mdl_a   <= {mdl_a[168:0], if_a.data_out};
      edges_a <= edges_a + 1;
    end
  end

  always @(posedge clk) begin
    prev_b <= if_b.clk_sr;
    if (if_b.valid) vcnt_b <= vcnt_b + 1;
    if (!if_b.busy && if_b.data_out) derr_b <= derr_b + 1;
    if (if_b.cap_sr) mdl_b <= cfg_b;
    else if (if_b.clk_sr && !prev_b) begin
      if (if_b.data_out !== mdl_b[0]) derr_b <= derr_b + 1;
      mdl_b   <= {if_b.data_out, mdl_b[169:1]};
      edges_b <= edges_b + 1;
    end
  end

  always @(posedge clk) begin
    prev_c <= if_c.clk_sr;
    if (if_c.valid) vcnt_c <= vcnt_c + 1;
    if (!if_c.busy && if_c.data_out) derr_c <= derr_c + 1;
    if (if_c.cap_sr) mdl_c <= cfg_c;
    else if (if_c.clk_sr && !prev_c) begin
      if (if_c.data_out !== mdl_c) derr_c <= derr_c + 1;
      mdl_c   <= if_c.data_out;
      edges_c <= edges_c + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [169:0] got, input logic [169:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // sel: 0 dout, 1 model, 2 clk_sr edges, 3 valid pulses, 4 data_out errors,
  // 5 {valid, busy, cap_sr, clk_sr, data_out}
  function automatic logic [169:0] peek(input int u, input int sel);
    logic [169:0] r;
    r = '0;
    case (u)
      0: case (sel)
           0: r = if_a.dout;
           1: r = mdl_a;
           2: r = 170'(edges_a);
           3: r = 170'(vcnt_a);
           4: r = 170'(derr_a);
           default: r = 170'({if_a.valid, if_a.busy, if_a.cap_sr, if_a.clk_sr, if_a.data_out});
         endcase
      1: case (sel)
           0: r = if_b.dout;
           1: r = mdl_b;
           2: r = 170'(edges_b);
           3: r = 170'(vcnt_b);
           4: r = 170'(derr_b);
           default: r = 170'({if_b.valid, if_b.busy, if_b.cap_sr, if_b.clk_sr, if_b.data_out});
         endcase
      default: case (sel)
           0: r = 170'(if_c.dout);
           1: r = 170'(mdl_c);
           2: r = 170'(edges_c);
           3: r = 170'(vcnt_c);
           4: r = 170'(derr_c);
           default: r = 170'({if_c.valid, if_c.busy, if_c.cap_sr, if_c.clk_sr, if_c.data_out});
         endcase
    endcase
    return r;
  endfunction

  // One readback on unit u; optional extra start pulse at cycle poke and
  // reset pulse at cycle rst_at. vcyc = cycle of valid, 0 if aborted, -1 on timeout.
  task automatic readback(input int u, input int poke, input int rst_at,
                          input logic [169:0] prev, output int vcyc);
    int cyc;
    start_v[u] = 1'b1;
    @(negedge clk);
    start_v[u] = 1'b0;
    cyc = 1;
    check($sformatf("u%0d_cap_cycle1", u), 170'({cap_v[u], busy_v[u]}), 170'(2'b11));
    while (!valid_v[u] && cyc < 700) begin
      if (cyc == 100) check($sformatf("u%0d_dout_hold", u), peek(u, 0), prev);
      start_v[u] = (cyc == poke);
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", peek(u, 5), '0);
        check("abort_dout", peek(u, 0), '0);
        vcyc = 0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start_v[u] = 1'b0;
    vcyc = valid_v[u] ? cyc : -1;
    if (valid_v[u]) check($sformatf("u%0d_done_ctl", u), peek(u, 5), 170'(5'b10000));
  endtask

  logic [169:0] pat [5];
  logic [169:0] e0, v0;
  int vcyc, cyc, got, vprev, lowcnt;

  initial begin
    pat[0] = {85{2'b10}};
    pat[1] = {1'b1, 168'd0, 1'b1};
    pat[2] = {10{17'h1_2345}};
    pat[3] = ~{85{2'b10}};
    pat[4] = 170'h1234_5678_9abc_def0_1357_9bdf_0246_8ace;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ctl", peek(0, 5), '0);
    check("rst_dout", peek(0, 0), '0);
    check("rst_ctl_c", peek(2, 5), '0);

    // MSB-first readback with a stray start at cycle 100
    cfg_a = pat[0];
    e0 = peek(0, 2);
    v0 = peek(0, 3);
    readback(0, 100, -1, '0, vcyc);
    check("a_valid_cycle", 170'(vcyc), 170'(512));
    check("a_dout", peek(0, 0), pat[0]);
    check("a_edges", peek(0, 2) - e0, 170'(170));
    check("a_model_intact", peek(0, 1), pat[0]);
    repeat (8) @(negedge clk);
    check("a_one_valid", peek(0, 3) - v0, 170'(1));
    check("a_idle_after", peek(0, 5), '0);

    // Reset in the middle, then a clean readback
    cfg_a = pat[1];
    readback(0, -1, 300, pat[0], vcyc);
    check("abort_vcyc", 170'(vcyc), '0);
    repeat (2) @(negedge clk);
    e0 = peek(0, 2);
    readback(0, -1, -1, '0, vcyc);
    check("b_valid_cycle", 170'(vcyc), 170'(512));
    check("b_dout", peek(0, 0), pat[1]);
    check("b_edges", peek(0, 2) - e0, 170'(170));
    check("b_model_intact", peek(0, 1), pat[1]);

    // Back-to-back with start held high, new pattern each pass
    @(negedge clk);
    cfg_a = pat[2];
    start_v[0] = 1'b1;
    got = 0; cyc = 0; vprev = 0; lowcnt = 0;
    while (got < 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (got >= 1 && !busy_v[0]) lowcnt++;
      if (valid_v[0]) begin
        check($sformatf("b2b_dout%0d", got), peek(0, 0), pat[2 + got]);
        if (got > 0) check($sformatf("b2b_period%0d", got), 170'(cyc - vprev), 170'(513));
        vprev = cyc;
        got++;
        if (got < 3) cfg_a = pat[2 + got];
        else start_v[0] = 1'b0;
      end
    end
    start_v[0] = 1'b0;
    check("b2b_count", 170'(got), 170'(3));
    check("b2b_busy_low", 170'(lowcnt), 170'(4));
    check("a_data_out_errs", peek(0, 4), '0);

    // LSB-first, one-hot bit 0
    cfg_b = 170'd1;
    e0 = peek(1, 2);
    readback(1, -1, -1, '0, vcyc);
    check("lsb_valid_cycle", 170'(vcyc), 170'(512));
    check("lsb_dout", peek(1, 0), 170'd1);
    check("lsb_edges", peek(1, 2) - e0, 170'(170));
    check("lsb_model_intact", peek(1, 1), 170'd1);
    check("lsb_data_out_errs", peek(1, 4), '0);

    // One-bit chain
    cfg_c = 1'b1;
    e0 = peek(2, 2);
    readback(2, -1, -1, '0, vcyc);
    check("w1_valid_cycle", 170'(vcyc), 170'(5));
    check("w1_dout", peek(2, 0), 170'd1);
    check("w1_edges", peek(2, 2) - e0, 170'(1));
    check("w1_model_intact", peek(2, 1), 170'd1);
    check("w1_data_out_errs", peek(2, 4), '0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
